// File: rtl/bht_pkg.sv
// Shared types for the branch history table arbiter: predictor encoding,
// arbiter states and the queued update entry.
package bht_pkg;

  typedef logic [1:0] bht_state_t;

  localparam bht_state_t SNT = 2'b00;
  localparam bht_state_t WNT = 2'b01;
  localparam bht_state_t ST  = 2'b10;
  localparam bht_state_t WT  = 2'b11;

  typedef enum logic {INIT, RUN} arb_state_t;

  // The update entry is sized for the default table; ENTRIES on the top must match.
  localparam int unsigned BHT_ENTRIES = 16;
  localparam int unsigned BHT_IDX_W   = $clog2(BHT_ENTRIES);

  typedef struct packed {
    logic [BHT_IDX_W-1:0] index;
    logic                 mispredicted;
  } upd_entry_t;

endpackage

// File: rtl/bht_access_arbiter_if.sv
// Fetch lookup/response and execute update channels of the BHT arbiter.
interface bht_access_arbiter_if #(
  parameter int unsigned ENTRIES = 16
) ();
  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic            lookup_valid;
  logic            lookup_ready;
  logic [IdxW-1:0] lookup_index;
  logic            resp_valid;
  logic            resp_taken;
  logic            upd_valid;
  logic            upd_ready;
  logic [IdxW-1:0] upd_index;
  logic            upd_mispredicted;

  modport master (
    output lookup_valid, lookup_index, upd_valid, upd_index, upd_mispredicted,
    input  lookup_ready, resp_valid, resp_taken, upd_ready
  );

  modport slave (
    input  lookup_valid, lookup_index, upd_valid, upd_index, upd_mispredicted,
    output lookup_ready, resp_valid, resp_taken, upd_ready
  );
endinterface

// File: rtl/bht_state_next.sv
// Two-bit predictor transition: a miss walks toward the opposite prediction,
// a hit settles into the strong state of the current prediction.
module bht_state_next
  import bht_pkg::*;
(
  input  bht_state_t cur_i,
  input  logic       mispredicted_i,
  output bht_state_t nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    unique case (cur_i)
      SNT: nxt_o = mispredicted_i ? WNT : SNT;
      WNT: nxt_o = mispredicted_i ? ST  : SNT;
      ST:  nxt_o = mispredicted_i ? WT  : ST;
      WT:  nxt_o = mispredicted_i ? SNT : ST;
    endcase
  end

endmodule

// File: rtl/bht_access_arbiter.sv
// Branch history table with a single access slot shared between fetch lookups
// (priority) and a queue of execute-side updates, plus the clear sweep.
module bht_access_arbiter
  import bht_pkg::*;
#(
  parameter int unsigned ENTRIES      = BHT_ENTRIES,
  parameter int unsigned UPD_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  bht_access_arbiter_if.slave        bus,
  output logic                       init_done
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned PtrW = $clog2(UPD_DEPTH);
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  arb_state_t      state_q, state_d;
  logic [IdxW-1:0] sweep_q, sweep_d;
  logic [PtrW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_taken_q, resp_taken_d;

  upd_entry_t fifo_q  [UPD_DEPTH];
  bht_state_t table_q [ENTRIES];

  logic       run, fifo_empty, fifo_full, starved;
  logic       lookup_fire, push, pop;
  upd_entry_t head;
  bht_state_t head_nxt;

  assign run        = (state_q == RUN);
  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign starved    = !fifo_empty && (starve_q == StW'(STARVE_LIMIT));

  // Readies come from registered state only, so fetch never sees a comb path.
  assign bus.lookup_ready = run && !starved;
  assign bus.upd_ready    = run && !fifo_full;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_taken   = resp_taken_q;
  assign init_done        = run;

  assign lookup_fire = bus.lookup_valid && bus.lookup_ready;
  assign push        = bus.upd_valid && bus.upd_ready;
  assign pop         = run && !lookup_fire && !fifo_empty;
  assign head        = fifo_q[rd_q[PtrW-1:0]];

  bht_state_next u_state_next (
    .cur_i          (table_q[head.index]),
    .mispredicted_i (head.mispredicted),
    .nxt_o          (head_nxt)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == IdxW'(ENTRIES - 1)) state_d = RUN;
      end
      RUN: ;
    endcase
    if (clr) begin
      state_d = INIT;
      sweep_d = '0;
    end
  end

  always_comb begin
    wr_d     = clr ? '0 : wr_q + (PtrW + 1)'(push);
    rd_d     = clr ? '0 : rd_q + (PtrW + 1)'(pop);
    starve_d = '0;
    if (!clr && lookup_fire && !fifo_empty) begin
      starve_d = (starve_q == StW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end
    resp_valid_d = lookup_fire;
    resp_taken_d = lookup_fire && table_q[bus.lookup_index][1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      starve_q     <= starve_d;
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
    end
  end

  // Storage arrays carry no reset; the sweep initialises the table.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      table_q[sweep_q] <= SNT;
    end else if (pop) begin
      table_q[head.index] <= head_nxt;
    end
    if (push) begin
      fifo_q[wr_q[PtrW-1:0]] <= '{index: bus.upd_index, mispredicted: bus.upd_mispredicted};
    end
  end

endmodule

// File: tb/tb_bht_access_arbiter.sv
// Directed bench: stimulus pushes expected responses into a scoreboard queue,
// a negedge monitor pops and compares whenever a response is presented.
module tb_bht_access_arbiter;

  logic clk;
  logic rst_n;
  logic clr;
  logic init_done;

  int n_total = 0;
  int n_pass  = 0;
  bit sb[$];

  bht_access_arbiter_if #(.ENTRIES(16)) bus ();

  bht_access_arbiter #(
    .ENTRIES      (16),
    .UPD_DEPTH    (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bus       (bus),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        bit e;
        e = sb.pop_front();
        chk("resp_taken", {31'd0, bus.resp_taken}, {31'd0, e});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int idx, input bit exp);
    int n;
    n = 0;
    bus.lookup_valid = 1'b1;
    bus.lookup_index = 4'(idx);
    @(negedge clk);
    while (!bus.lookup_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.lookup_ready) sb.push_back(exp);
    else chk("lookup_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.lookup_valid = 1'b0;
  endtask

  task automatic push_upd(input int idx, input bit mis);
    int n;
    n = 0;
    bus.upd_valid        = 1'b1;
    bus.upd_index        = 4'(idx);
    bus.upd_mispredicted = mis;
    @(negedge clk);
    while (!bus.upd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.upd_ready) chk("upd_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit m4[4];
    m4 = '{1'b1, 1'b1, 1'b0, 1'b0};
    rst_n                = 1'b0;
    clr                  = 1'b0;
    bus.lookup_valid     = 1'b1;
    bus.lookup_index     = 4'd5;
    bus.upd_valid        = 1'b0;
    bus.upd_index        = 4'd0;
    bus.upd_mispredicted = 1'b0;

    // Reset values, then sweep with lookup_valid held high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lookup_ready", {31'd0, bus.lookup_ready}, 32'd0);
    chk("rst_upd_ready", {31'd0, bus.upd_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_taken", {31'd0, bus.resp_taken}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("sweep_lookup_ready", {31'd0, bus.lookup_ready}, 32'd0);
      chk("sweep_init_done", {31'd0, init_done}, 32'd0);
    end
    @(negedge clk);
    chk("init_done_rise", {31'd0, init_done}, 32'd1);
    chk("first_lookup_ready", {31'd0, bus.lookup_ready}, 32'd1);
    sb.push_back(1'b0);
    @(posedge clk);
    #1;
    bus.lookup_valid = 1'b0;

    // Idle lookup port: idx3 00->01->10->10, idx7 00->01.
    push_upd(3, 1'b1);
    push_upd(3, 1'b1);
    push_upd(3, 1'b0);
    push_upd(7, 1'b1);
    idle(4);
    lookup(3, 1'b1);
    lookup(5, 1'b0);
    lookup(7, 1'b0);

    // Starvation: one queued update (idx7 01->10) against continuous lookups.
    bus.upd_valid        = 1'b1;
    bus.upd_index        = 4'd7;
    bus.upd_mispredicted = 1'b1;
    bus.lookup_valid     = 1'b1;
    bus.lookup_index     = 4'd7;
    @(negedge clk);
    chk("t3_upd_ready", {31'd0, bus.upd_ready}, 32'd1);
    chk("t3_lookup_ready0", {31'd0, bus.lookup_ready}, 32'd1);
    sb.push_back(1'b0);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_lookup_ready", {31'd0, bus.lookup_ready}, 32'd1);
      sb.push_back(1'b0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t3_starved", {31'd0, bus.lookup_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_ready_after_pop", {31'd0, bus.lookup_ready}, 32'd1);
    sb.push_back(1'b1);
    @(posedge clk);
    #1;
    bus.lookup_valid = 1'b0;

    // Fill the FIFO under saturating lookups; idx12 ends at 11.
    bus.lookup_valid = 1'b1;
    bus.lookup_index = 4'd0;
    bus.upd_valid    = 1'b1;
    bus.upd_index    = 4'd12;
    for (int k = 0; k < 4; k++) begin
      bus.upd_mispredicted = m4[k];
      @(negedge clk);
      chk("t4_upd_ready", {31'd0, bus.upd_ready}, 32'd1);
      chk("t4_lookup_ready", {31'd0, bus.lookup_ready}, 32'd1);
      sb.push_back(1'b0);
      @(posedge clk);
      #1;
    end
    bus.upd_mispredicted = 1'b1;
    @(negedge clk);
    chk("t4_full_upd_ready", {31'd0, bus.upd_ready}, 32'd0);
    chk("t4_full_lookup_ready", {31'd0, bus.lookup_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_after_pop_upd_ready", {31'd0, bus.upd_ready}, 32'd1);
    chk("t4_after_pop_lookup_ready", {31'd0, bus.lookup_ready}, 32'd1);
    sb.push_back(1'b0);
    @(posedge clk);
    #1;
    bus.upd_valid    = 1'b0;
    bus.lookup_valid = 1'b0;
    idle(6);
    lookup(12, 1'b1);

    // WT miss -> SNT: lookup with the update still queued sees the old value.
    bus.lookup_valid     = 1'b1;
    bus.lookup_index     = 4'd12;
    bus.upd_valid        = 1'b1;
    bus.upd_index        = 4'd12;
    bus.upd_mispredicted = 1'b1;
    @(negedge clk);
    chk("t5_lookup_ready", {31'd0, bus.lookup_ready}, 32'd1);
    chk("t5_upd_ready", {31'd0, bus.upd_ready}, 32'd1);
    sb.push_back(1'b1);
    @(posedge clk);
    #1;
    bus.lookup_valid = 1'b0;
    bus.upd_valid    = 1'b0;
    @(posedge clk);
    #1;
    lookup(12, 1'b0);

    // clr with 3 queued updates, an accepted lookup and a same-cycle push.
    bus.lookup_valid     = 1'b1;
    bus.lookup_index     = 4'd0;
    bus.upd_valid        = 1'b1;
    bus.upd_index        = 4'd5;
    bus.upd_mispredicted = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_upd_ready", {31'd0, bus.upd_ready}, 32'd1);
      chk("t6_lookup_ready", {31'd0, bus.lookup_ready}, 32'd1);
      sb.push_back(1'b0);
      @(posedge clk);
      #1;
    end
    bus.lookup_index = 4'd3;
    clr              = 1'b1;
    @(negedge clk);
    chk("t6_clr_lookup_ready", {31'd0, bus.lookup_ready}, 32'd1);
    sb.push_back(1'b1);
    @(posedge clk);
    #1;
    clr              = 1'b0;
    bus.lookup_valid = 1'b0;
    bus.upd_valid    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clr_sweep_lookup_ready", {31'd0, bus.lookup_ready}, 32'd0);
      chk("clr_sweep_upd_ready", {31'd0, bus.upd_ready}, 32'd0);
    end
    @(negedge clk);
    chk("clr_init_done", {31'd0, init_done}, 32'd1);
    chk("clr_lookup_ready", {31'd0, bus.lookup_ready}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) lookup(i, 1'b0);
    idle(4);
    lookup(5, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
